// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: receive side of a 4-slot TDM link.
// Deserialises one WIDTH-bit word per valid beat into four channel outputs, updated together
// once per complete frame. Hunts for the frame-sync marker on slot 0, tracks lock and flags
// alignment violations.
// Optional feature: define TDM_DEMUX_PARITY_EN to enable even-parity checking per beat.
// A frame containing a bad beat is dropped at completion.

module tdm_demux_1to4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  input  logic             din_par,
  output logic [WIDTH-1:0] i0,
  output logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] i3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err,
  output logic             par_err
);

  typedef enum logic [0:0] {StHunt, StRun} state_e;

  state_e           state_q;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
  logic [WIDTH-1:0] i0_q, i1_q, i2_q, i3_q;
  logic             frame_valid_q;
  logic             sync_err_q;

  // Per-beat event decode
  logic start_frame;  // sync beat: (re)starts a frame at slot 0
  logic go_hunt;      // non-sync beat where slot 0 was expected
  logic store_mid;    // non-sync beat for slots 1..3
  logic complete;     // slot-3 beat closes the frame
  logic sync_viol;    // alignment violation while running
  logic frame_ok;     // completing frame is clean enough to publish

  // Classify the current beat against the expected slot
  always_comb begin
    start_frame = 1'b0;
    go_hunt     = 1'b0;
    store_mid   = 1'b0;
    sync_viol   = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        start_frame = 1'b1;
        // A sync beat is only a violation when it interrupts a frame in progress
        sync_viol   = (state_q == StRun) && (slot_q != 2'd0);
      end else if (state_q == StRun) begin
        if (slot_q == 2'd0) begin
          go_hunt   = 1'b1;
          sync_viol = 1'b1;
        end else begin
          store_mid = 1'b1;
        end
      end
    end
    complete = store_mid && (slot_q == 2'd3);
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic beat_bad;
  logic bad_q;
  logic par_err_q;

  assign beat_bad = ^{din, din_par};
  assign frame_ok = ~(bad_q | beat_bad);

  // Track whether the frame in progress has seen a parity error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= din_valid & beat_bad;
      if (start_frame) begin
        bad_q <= beat_bad;
      end else if (go_hunt || complete) begin
        bad_q <= 1'b0;
      end else if (store_mid) begin
        bad_q <= bad_q | beat_bad;
      end
    end
  end

  assign par_err = par_err_q;
`else
  logic unused_din_par;

  assign unused_din_par = din_par;
  assign frame_ok       = 1'b1;
  assign par_err        = 1'b0;
`endif

  // Hunt/run FSM with slot counter, shadow capture and atomic output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      slot_q        <= 2'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      i0_q          <= '0;
      i1_q          <= '0;
      i2_q          <= '0;
      i3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= sync_viol;
      if (start_frame) begin
        // Any partial frame is abandoned; stale shadow words get overwritten before completion
        state_q <= StRun;
        sh0_q   <= din;
        slot_q  <= 2'd1;
      end else if (go_hunt) begin
        state_q <= StHunt;
        slot_q  <= 2'd0;
      end else if (store_mid) begin
        slot_q <= slot_q + 2'd1;
        unique case (slot_q)
          2'd1: sh1_q <= din;
          2'd2: sh2_q <= din;
          default: begin
            if (frame_ok) begin
              i0_q          <= sh0_q;
              i1_q          <= sh1_q;
              i2_q          <= sh2_q;
              i3_q          <= din;
              frame_valid_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign i0          = i0_q;
  assign i1          = i1_q;
  assign i2          = i2_q;
  assign i3          = i3_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == StRun);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Self-checking bench for tdm_demux_1to4: scoreboard of expected frames popped on frame_valid.
module tb_tdm_demux_1to4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic       din_par;
  logic [7:0] i0, i1, i2, i3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
  logic       par_err;

  int          total;
  int          bad;
  int          fv_count;
  logic [31:0] exp_q[$];
  logic [31:0] prev_out;

  tdm_demux_1to4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .din_par    (din_par),
    .i0         (i0),
    .i1         (i1),
    .i2         (i2),
    .i3         (i3),
    .frame_valid(frame_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every frame_valid pops one expected frame; outputs may not move otherwise
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] cur;
    cur = {i0, i1, i2, i3};
    if (!rst_n) begin
      prev_out = 32'h0;
    end else begin
      if (frame_valid === 1'b1) begin
        fv_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL frame_unexpected: got %h, no frame expected", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL frame_data: got %h, required %h", cur, e);
          end
        end
      end else if (cur !== prev_out) begin
        total++;
        bad++;
        $display("FAIL outputs_stable: got %h without frame_valid, required %h", cur, prev_out);
      end
      prev_out = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // Drive one beat; returns just after the sampling edge
  task automatic send(input logic [7:0] d, input logic fs, input logic flip);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = fs;
    din_par    = (^d) ^ flip;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [31:0] f);
    send(f[31:24], 1'b1, 1'b0);
    send(f[23:16], 1'b0, 1'b0);
    send(f[15:8], 1'b0, 1'b0);
    send(f[7:0], 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    din = '0; din_valid = 1'b0; frame_sync = 1'b0; din_par = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({i0, i1, i2, i3} !== 32'h0) begin
      bad++; $display("FAIL reset_outputs: got %h, required 0", {i0, i1, i2, i3});
    end
    total++;
    if ({frame_valid, sync_err, par_err, locked} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b, required 0000",
                      {frame_valid, sync_err, par_err, locked});
    end
    total++;
    if (slot !== 2'd0) begin
      bad++; $display("FAIL reset_slot: got %0d, required 0", slot);
    end
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int f0;
    f0 = fv_count;
    exp_q.push_back(32'h11223344);
    send(8'h11, 1'b1, 1'b0);
    total++;
    if (locked !== 1'b1 || slot !== 2'd1) begin
      bad++; $display("FAIL basic_lock: got locked=%b slot=%0d, required 1/1", locked, slot);
    end
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++; $display("FAIL basic_early_fv: got %b, required 0", frame_valid);
    end
    send(8'h44, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || slot !== 2'd0) begin
      bad++; $display("FAIL basic_fv: got fv=%b slot=%0d, required 1/0", frame_valid, slot);
    end
    idle(1);
    total++;
    if (fv_count !== f0 + 1) begin
      bad++; $display("FAIL basic_count: got %0d, required %0d", fv_count, f0 + 1);
    end
  endtask

  task automatic test_gaps;
    int f0;
    logic [31:0] f;
    f0 = fv_count;
    f = 32'h11223344;
    exp_q.push_back(f);
    for (int k = 0; k < 4; k++) begin
      send(f[31-8*k -: 8], (k == 0), 1'b0);
      if (k < 3) begin
        total++;
        if (frame_valid !== 1'b0) begin
          bad++; $display("FAIL gaps_early_fv: beat %0d got %b, required 0", k, frame_valid);
        end
      end
      idle($urandom_range(1, 3));
    end
    total++;
    if (fv_count !== f0 + 1) begin
      bad++; $display("FAIL gaps_count: got %0d, required %0d", fv_count, f0 + 1);
    end
  endtask

  task automatic test_resync;
    int f0;
    f0 = fv_count;
    send(8'hA0, 1'b1, 1'b0);
    idle(1);
    send(8'hA1, 1'b0, 1'b0);
    send(8'hB0, 1'b1, 1'b0);
    total++;
    if (sync_err !== 1'b1 || locked !== 1'b1 || slot !== 2'd1) begin
      bad++; $display("FAIL resync_err: got err=%b locked=%b slot=%0d, required 1/1/1",
                      sync_err, locked, slot);
    end
    exp_q.push_back(32'hB0B1B2B3);
    send(8'hB1, 1'b0, 1'b0);
    total++;
    if (sync_err !== 1'b0) begin
      bad++; $display("FAIL resync_pulse: got %b, required 0", sync_err);
    end
    send(8'hB2, 1'b0, 1'b0);
    send(8'hB3, 1'b0, 1'b0);
    idle(1);
    total++;
    if (fv_count !== f0 + 1) begin
      bad++; $display("FAIL resync_count: got %0d, required %0d", fv_count, f0 + 1);
    end
  endtask

  task automatic test_slot0_violation;
    int f0;
    f0 = fv_count;
    send(8'h55, 1'b0, 1'b0);
    total++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0) begin
      bad++; $display("FAIL viol_err: got err=%b locked=%b slot=%0d, required 1/0/0",
                      sync_err, locked, slot);
    end
    send(8'h66, 1'b0, 1'b0);
    total++;
    if (sync_err !== 1'b0 || locked !== 1'b0 || slot !== 2'd0) begin
      bad++; $display("FAIL viol_hunt: got err=%b locked=%b slot=%0d, required 0/0/0",
                      sync_err, locked, slot);
    end
    send(8'h77, 1'b0, 1'b0);
    idle(1);
    total++;
    if (fv_count !== f0) begin
      bad++; $display("FAIL viol_count: got %0d, required %0d", fv_count, f0);
    end
  endtask

  task automatic test_reset_midframe;
    int f0;
    send(8'hC0, 1'b1, 1'b0);
    send(8'hC1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({i0, i1, i2, i3} !== 32'h0 || locked !== 1'b0 || slot !== 2'd0) begin
      bad++; $display("FAIL midreset: got out=%h locked=%b slot=%0d, required 0/0/0",
                      {i0, i1, i2, i3}, locked, slot);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h99, 1'b0, 1'b0);
    total++;
    if (locked !== 1'b0 || slot !== 2'd0) begin
      bad++; $display("FAIL midreset_hunt: got locked=%b slot=%0d, required 0/0", locked, slot);
    end
    f0 = fv_count;
    exp_q.push_back(32'hC0C1C2C3);
    send_frame(32'hC0C1C2C3);
    idle(1);
    total++;
    if (fv_count !== f0 + 1) begin
      bad++; $display("FAIL midreset_count: got %0d, required %0d", fv_count, f0 + 1);
    end
  endtask

  task automatic test_parity;
    int f0;
    f0 = fv_count;
    send(8'hD0, 1'b1, 1'b0);
    send(8'hD1, 1'b0, 1'b0);
    send(8'hD2, 1'b0, 1'b1);
    total++;
`ifdef TDM_DEMUX_PARITY_EN
    if (par_err !== 1'b1) begin
      bad++; $display("FAIL parity_err: got %b, required 1", par_err);
    end
`else
    if (par_err !== 1'b0) begin
      bad++; $display("FAIL parity_tied: got %b, required 0", par_err);
    end
    exp_q.push_back(32'hD0D1D2D3);
`endif
    send(8'hD3, 1'b0, 1'b0);
    total++;
    if (par_err !== 1'b0) begin
      bad++; $display("FAIL parity_pulse: got %b, required 0", par_err);
    end
    idle(1);
    total++;
`ifdef TDM_DEMUX_PARITY_EN
    if (fv_count !== f0 || {i0, i1, i2, i3} !== 32'hC0C1C2C3) begin
      bad++; $display("FAIL parity_drop: got count=%0d out=%h, required %0d/c0c1c2c3",
                      fv_count, {i0, i1, i2, i3}, f0);
    end
`else
    if (fv_count !== f0 + 1) begin
      bad++; $display("FAIL parity_ignored: got %0d, required %0d", fv_count, f0 + 1);
    end
`endif
    f0 = fv_count;
    exp_q.push_back(32'hE0E1E2E3);
    send_frame(32'hE0E1E2E3);
    idle(1);
    total++;
    if (fv_count !== f0 + 1) begin
      bad++; $display("FAIL parity_recover: got %0d, required %0d", fv_count, f0 + 1);
    end
  endtask

  task automatic test_back_to_back;
    int f0;
    logic [63:0] w;
    f0 = fv_count;
    w = 64'h1F2E3D4C_5B6A7988;
    exp_q.push_back(w[63:32]);
    exp_q.push_back(w[31:0]);
    for (int k = 0; k < 8; k++) begin
      send(w[63-8*k -: 8], (k % 4 == 0), 1'b0);
      total++;
      if (frame_valid !== (k % 4 == 3)) begin
        bad++; $display("FAIL b2b_fv: beat %0d got %b, required %b", k, frame_valid, (k % 4 == 3));
      end
    end
    idle(1);
    total++;
    if (fv_count !== f0 + 2) begin
      bad++; $display("FAIL b2b_count: got %0d, required %0d", fv_count, f0 + 2);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    fv_count = 0;
    prev_out = 32'h0;
    test_reset();
    test_basic();
    test_gaps();
    test_resync();
    test_slot0_violation();
    test_reset_midframe();
    test_parity();
    test_back_to_back();
    idle(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
